// File: rtl/seq_gen_pkg.sv
// ============================================================================
//  Module      : seq_gen_pkg
//  Description : Mode encoding and shared constants for the prescaled
//                sequence generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_GRAY    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  // Divider value the legacy board used for a visible blink rate.
  localparam int unsigned DIV_DEFAULT = 25000;

endpackage : seq_gen_pkg

`default_nettype wire

// File: rtl/seq_prescaler.sv
// ============================================================================
//  Module      : seq_prescaler
//  Description : Programmable clock-enable divider emitting a one-cycle step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_prescaler #(
  parameter int DIV_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic             step_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             w_due;

  // Using >= rather than == lets a lowered div_val take effect immediately.
  assign w_due  = (cnt_q >= div_val_i);
  assign step_o = en_i & w_due & ~clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = w_due ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : seq_prescaler

`default_nettype wire

// File: rtl/seq_gen_prescaled.sv
// ============================================================================
//  Module      : seq_gen_prescaled
//  Description : Prescaled binary/Gray/Johnson sequence generator with load.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gen_prescaled
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             clk_slow
);

  localparam logic [WIDTH-1:0] c_ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] c_JOHN_LAST = {1'b1, {(WIDTH-1){1'b0}}};

  mode_e            w_mode;
  logic [1:0]       mode_q;
  logic             w_mode_chg;
  logic             w_step;
  logic [WIDTH-1:0] w_b_inc;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             slow_q, slow_d;

  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (mode != mode_q);
  assign w_b_inc    = b_q + 1'b1;

  seq_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en_i     (en),
    .clear_i  (load | w_mode_chg),
    .div_val_i(div_val),
    .step_o   (w_step)
  );

  // Priority: load, then mode-change zeroing, then a prescaler step.
  always_comb begin
    q_d    = q_q;
    b_d    = b_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    slow_d = slow_q;
    if (load) begin
      b_d = load_val;
      case (w_mode)
        MODE_GRAY:    q_d = load_val ^ (load_val >> 1);
        MODE_JOHNSON: q_d = '0;
        default:      q_d = load_val;
      endcase
    end else if (w_mode_chg) begin
      q_d = '0;
      b_d = '0;
    end else if (w_step) begin
      tick_d = 1'b1;
      slow_d = ~slow_q;
      case (w_mode)
        MODE_UP: begin
          q_d    = q_q + 1'b1;
          wrap_d = (q_q == c_ALL_ONES);
        end
        MODE_DOWN: begin
          q_d    = q_q - 1'b1;
          wrap_d = (q_q == '0);
        end
        MODE_GRAY: begin
          b_d    = w_b_inc;
          q_d    = w_b_inc ^ (w_b_inc >> 1);
          wrap_d = (b_q == c_ALL_ONES);
        end
        default: begin
          q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
          wrap_d = (q_q == c_JOHN_LAST);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      b_q    <= '0;
      mode_q <= 2'b00;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      slow_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      b_q    <= b_d;
      mode_q <= mode;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      slow_q <= slow_d;
    end
  end

  assign q        = q_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign clk_slow = slow_q;

endmodule : seq_gen_prescaled

`default_nettype wire
